// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file.
// CSR addresses, write-mode encodings and mstatus field positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_wsc_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  // MIE, MPIE and MPP; everything else in mstatus is hardwired.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_1888;

endpackage

// File: rtl/csr_regfile_m_counter64.sv
// 64-bit counter split into two W-bit CSR halves.
// Ports: clk, rst, inc, we_lo/we_hi + wdata, cnt (2*W bits).
module csr_counter64 #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           we_lo,
  input  logic           we_hi,
  input  logic [W-1:0]   wdata,
  output logic [2*W-1:0] cnt
);

  logic [2*W-1:0] cnt_q;
  logic [2*W-1:0] cnt_d;

  // A write to either half suppresses this cycle's increment
  // for the whole counter; the unwritten half holds.
  always_comb begin
    cnt_d = cnt_q;
    if (we_lo || we_hi) begin
      if (we_lo) cnt_d[W-1:0]   = wdata;
      if (we_hi) cnt_d[2*W-1:W] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/csr_regfile_m.sv
// Machine-mode CSR file: CSRRW/RS/RC, trap entry, MRET, redirect PC.
// Ports: csr read/write, trap/mret inputs, redirect_pc, CSR views.
// Optional mcycle/minstret counters under CSR_COUNTERS_EN.
module csr_regfile_m
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter logic [XLEN-1:0] MHARTID_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            raddr_illegal,
  input  logic            csr_w,
  input  logic [1:0]      csr_wsc_mode,
  input  logic [11:0]     waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            instr_retire,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic            mie_global
);

  logic            mie_q,      mie_d;
  logic            mpie_q,     mpie_d;
  logic [XLEN-1:0] mie_csr_q,  mie_csr_d;
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;
  logic [XLEN-1:0] mtval_q,    mtval_d;

  logic [XLEN-1:0] mstatus_v;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] mtvec_base;
  logic            wr_en;

  always_comb begin
    mstatus_v                                = '0;
    mstatus_v[MSTATUS_MIE]                   = mie_q;
    mstatus_v[MSTATUS_MPIE]                  = mpie_q;
    mstatus_v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

`ifdef CSR_COUNTERS_EN
  logic [2*XLEN-1:0] mcycle_cnt;
  logic [2*XLEN-1:0] minstret_cnt;
  logic              cyc_we_lo, cyc_we_hi;
  logic              ret_we_lo, ret_we_hi;

  assign cyc_we_lo = wr_en && (waddr == CSR_MCYCLE);
  assign cyc_we_hi = wr_en && (waddr == CSR_MCYCLEH);
  assign ret_we_lo = wr_en && (waddr == CSR_MINSTRET);
  assign ret_we_hi = wr_en && (waddr == CSR_MINSTRETH);

  csr_counter64 #(.W(XLEN)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (cyc_we_lo),
    .we_hi (cyc_we_hi),
    .wdata (new_val),
    .cnt   (mcycle_cnt)
  );

  csr_counter64 #(.W(XLEN)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire),
    .we_lo (ret_we_lo),
    .we_hi (ret_we_hi),
    .wdata (new_val),
    .cnt   (minstret_cnt)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  function automatic logic csr_impl(input logic [11:0] a);
    logic ok;
    ok = 1'b1;
    unique case (a)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC,
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MHARTID: ok = 1'b1;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MCYCLEH,
      CSR_MINSTRET, CSR_MINSTRETH: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] csr_rd(input logic [11:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    unique case (a)
      CSR_MSTATUS:   v = mstatus_v;
      CSR_MIE:       v = mie_csr_q;
      CSR_MTVEC:     v = mtvec_q;
      CSR_MSCRATCH:  v = mscratch_q;
      CSR_MEPC:      v = mepc_q;
      CSR_MCAUSE:    v = mcause_q;
      CSR_MTVAL:     v = mtval_q;
      CSR_MHARTID:   v = MHARTID_VAL;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    v = mcycle_cnt[XLEN-1:0];
      CSR_MCYCLEH:   v = mcycle_cnt[2*XLEN-1:XLEN];
      CSR_MINSTRET:  v = minstret_cnt[XLEN-1:0];
      CSR_MINSTRETH: v = minstret_cnt[2*XLEN-1:XLEN];
`endif
      default:       v = '0;
    endcase
    return v;
  endfunction

  // Reads see pre-update state; no write bypass.
  always_comb begin
    rdata         = csr_rd(raddr);
    raddr_illegal = !csr_impl(raddr);
  end

  always_comb begin
    old_val = csr_rd(waddr);
    new_val = old_val;
    unique case (csr_wsc_e'(csr_wsc_mode))
      CSR_NOP: new_val = old_val;
      CSR_RW:  new_val = wdata;
      CSR_RS:  new_val = old_val | wdata;
      CSR_RC:  new_val = old_val & ~wdata;
    endcase
  end

  // Trap and mret drop a same-cycle CSR write entirely.
  assign wr_en = csr_w && (csr_wsc_mode != CSR_NOP)
              && !trap_valid && !mret;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mie_csr_d  = mie_csr_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid) begin
      mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      unique case (waddr)
        CSR_MSTATUS: begin
          mie_d  = new_val[MSTATUS_MIE]  & MSTATUS_WMASK[MSTATUS_MIE];
          mpie_d = new_val[MSTATUS_MPIE] & MSTATUS_WMASK[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_csr_d  = new_val;
        // MODE 10/11 are reserved and collapse to direct.
        CSR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2],
                                    (new_val[1:0] == 2'b01) ? 2'b01 : 2'b00};
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_csr_q  <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mie_csr_q  <= mie_csr_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    redirect_pc = mtvec_base;
    if (trap_valid) begin
      if (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1])
        redirect_pc = mtvec_base + XLEN'({trap_cause[4:0], 2'b00});
      else
        redirect_pc = mtvec_base;
    end else if (mret) begin
      redirect_pc = mepc_q;
    end
  end

  assign mstatus    = mstatus_v;
  assign mtvec      = mtvec_q;
  assign mepc       = mepc_q;
  assign mcause     = mcause_q;
  assign mtval      = mtval_q;
  assign mie_global = mie_q;

endmodule

// File: tb/tb_csr_regfile_m.sv
// Directed self-checking bench for csr_regfile_m.
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_regfile_m;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        raddr_illegal;
  logic        csr_w;
  logic [1:0]  csr_wsc_mode;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic        instr_retire;
  logic [31:0] redirect_pc;
  logic [31:0] mstatus;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic        mie_global;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_regfile_m dut (
    .clk           (clk),
    .rst           (rst),
    .raddr         (raddr),
    .rdata         (rdata),
    .raddr_illegal (raddr_illegal),
    .csr_w         (csr_w),
    .csr_wsc_mode  (csr_wsc_mode),
    .waddr         (waddr),
    .wdata         (wdata),
    .trap_valid    (trap_valid),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .trap_tval     (trap_tval),
    .mret          (mret),
    .instr_retire  (instr_retire),
    .redirect_pc   (redirect_pc),
    .mstatus       (mstatus),
    .mtvec         (mtvec),
    .mepc          (mepc),
    .mcause        (mcause),
    .mtval         (mtval),
    .mie_global    (mie_global)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] m,
                    input logic [11:0] a,
                    input logic [31:0] d);
    csr_w        = 1'b1;
    csr_wsc_mode = m;
    waddr        = a;
    wdata        = d;
  endtask

  task automatic idle();
    csr_w        = 1'b0;
    csr_wsc_mode = 2'b00;
    trap_valid   = 1'b0;
    mret         = 1'b0;
    rst          = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; csr_w = 1'b0; csr_wsc_mode = '0;
    waddr = '0; wdata = '0; trap_valid = 1'b0; trap_cause = '0;
    trap_pc = '0; trap_tval = '0; mret = 1'b0; instr_retire = 1'b0;

    tick();
    idle();
    chk("rst_mtvec",   mtvec,   32'h0);
    chk("rst_mstatus", mstatus, 32'h0000_1800);
    chk("rst_redir",   redirect_pc, 32'h0);
    chk("rst_mie",     {31'b0, mie_global}, 32'h0);
    raddr = 12'h342; #1;
    chk("rd_mcause",     rdata, 32'h0);
    chk("rd_mcause_ill", {31'b0, raddr_illegal}, 32'h0);
    raddr = 12'h7C0; #1;
    chk("rd_unk",     rdata, 32'h0);
    chk("rd_unk_ill", {31'b0, raddr_illegal}, 32'h1);

    raddr = 12'h340;
    wr(2'b01, 12'h340, 32'hA5A5_0000); #1;
    chk("rw_pre", rdata, 32'h0);
    tick();
    wr(2'b10, 12'h340, 32'h0000_00FF); #1;
    chk("rs_pre", rdata, 32'hA5A5_0000);
    tick();
    wr(2'b11, 12'h340, 32'hA500_000F); #1;
    chk("rc_pre", rdata, 32'hA5A5_00FF);
    tick();
    idle(); #1;
    chk("rc_post", rdata, 32'h00A5_00F0);

    wr(2'b01, 12'h300, 32'hFFFF_FFFF);
    tick();
    chk("mstatus_mask", mstatus, 32'h0000_1888);
    wr(2'b01, 12'h300, 32'h0000_0008);
    tick();
    idle();
    chk("mstatus_mie", mstatus, 32'h0000_1808);
    chk("mie_global",  {31'b0, mie_global}, 32'h1);

    trap_valid = 1'b1; trap_cause = 32'h2;
    trap_pc = 32'h100; trap_tval = 32'hDEAD; #1;
    chk("trap_redir", redirect_pc, 32'h0);
    tick();
    idle();
    chk("trap_mepc",    mepc,    32'h100);
    chk("trap_mcause",  mcause,  32'h2);
    chk("trap_mtval",   mtval,   32'hDEAD);
    chk("trap_mstatus", mstatus, 32'h0000_1880);

    wr(2'b01, 12'h305, 32'h0000_2003);
    tick();
    chk("mtvec_warl", mtvec, 32'h0000_2000);
    wr(2'b01, 12'h305, 32'h0000_1001);
    tick();
    chk("mtvec_vec", mtvec, 32'h0000_1001);
    wr(2'b10, 12'h300, 32'h0000_0008);
    tick();
    idle();

    trap_valid = 1'b1; trap_cause = 32'h8000_0007;
    trap_pc = 32'h204; trap_tval = 32'h0; #1;
    chk("vec_redir", redirect_pc, 32'h0000_101C);
    tick();
    idle();
    chk("vec_mstatus", mstatus, 32'h0000_1880);
    mret = 1'b1; #1;
    chk("mret_redir", redirect_pc, 32'h204);
    tick();
    idle(); #1;
    chk("mret_mstatus", mstatus, 32'h0000_1888);
    chk("mret_mie",     {31'b0, mie_global}, 32'h1);
    chk("idle_redir",   redirect_pc, 32'h0000_1000);

    trap_valid = 1'b1; mret = 1'b1;
    trap_cause = 32'h5; trap_pc = 32'h300; trap_tval = 32'h77;
    wr(2'b01, 12'h341, 32'h0000_5550); #1;
    chk("prio_redir", redirect_pc, 32'h0000_1000);
    tick();
    idle();
    chk("prio_mepc",    mepc,    32'h300);
    chk("prio_mcause",  mcause,  32'h5);
    chk("prio_mstatus", mstatus, 32'h0000_1880);

    mret = 1'b1;
    wr(2'b01, 12'h340, 32'h0000_1234);
    tick();
    idle();
    raddr = 12'h340; #1;
    chk("mret_drop_wr", rdata,   32'h00A5_00F0);
    chk("mret2_status", mstatus, 32'h0000_1888);

    wr(2'b01, 12'h341, 32'h0000_0123);
    tick();
    chk("mepc_align", mepc, 32'h120);
    wr(2'b01, 12'hF14, 32'h0000_00FF);
    tick();
    idle();
    raddr = 12'hF14; #1;
    chk("mhartid_ro", rdata, 32'h0);

    rst = 1'b1; trap_valid = 1'b1;
    trap_cause = 32'h3; trap_pc = 32'h400; trap_tval = 32'h1;
    tick();
    idle();
    chk("rstw_mepc",    mepc,    32'h0);
    chk("rstw_mstatus", mstatus, 32'h0000_1800);
    chk("rstw_mtvec",   mtvec,   32'h0);

`ifdef CSR_COUNTERS_EN
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick();
    idle();
    raddr = 12'hB00; #1;
    chk("mcycle_wr", rdata, 32'hFFFF_FFFF);
    tick();
    raddr = 12'hB80; #1;
    chk("mcycle_hi", rdata, 32'h1);
    raddr = 12'hB00; #1;
    chk("mcycle_lo", rdata, 32'h0);
    raddr = 12'hB02; #1;
    chk("minstret_idle", rdata, 32'h0);
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0; #1;
    chk("minstret_inc", rdata, 32'h1);
`else
    raddr = 12'hB00; #1;
    chk("mcycle_ill", {31'b0, raddr_illegal}, 32'h1);
    chk("mcycle_rd0", rdata, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
